// File: rtl/riscv_mem_responder.sv
// Memory-side endpoint of the val/rdy memory request/response protocol.
// It performs word, halfword and byte reads and writes on an internal word
// array and returns each response a fixed number of cycles after the request
// was accepted. One instance serves one requester port.
//
// Request  {type[66], addr[65:34], len[33:32], data[31:0]}
// Response {type[34], len[33:32], data[31:0]}
// type: 0 = read, 1 = write.  len: 0/3 = word, 2 = halfword, 1 = byte.
module riscv_mem_responder #(
    parameter int ADDR_BITS    = 10,
    parameter int LAT          = 1,
    parameter int STALL_PERIOD = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [66:0] memreq_msg,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    output logic [34:0] memresp_msg,
    output logic        memresp_val
);

    localparam int NWORDS = 1 << ADDR_BITS;

    // The word array is deliberately not reset so that its contents survive a reset.
    logic [31:0]          mem [NWORDS];

    logic                 stall_q;
    logic                 accept;
    logic                 req_type;
    logic [1:0]           req_len;
    logic [31:0]          req_data;
    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           lane;
    logic                 unused_addr_hi;

    logic [31:0]          rd_word;
    logic [31:0]          rd_data;
    logic [31:0]          wr_word;
    logic [34:0]          resp_next;

    logic [LAT-1:0]       pipe_val;
    logic [34:0]          pipe_msg [LAT];

    assign req_type       = memreq_msg[66];
    assign req_len        = memreq_msg[33:32];
    assign req_data       = memreq_msg[31:0];
    assign lane           = memreq_msg[35:34];
    assign word_idx       = memreq_msg[ADDR_BITS+35:36];
    // Address bits above the array size are ignored, so the array wraps.
    assign unused_addr_hi = ^memreq_msg[65:ADDR_BITS+36];

    assign memreq_rdy = ~reset & ~stall_q;
    assign accept     = memreq_val & memreq_rdy;

    assign rd_word = mem[word_idx];

    // Read formatting: the selected lane is zero-extended. Write merge keeps the
    // bytes outside the selected lane.
    always_comb begin
        rd_data = rd_word;
        wr_word = req_data;
        case (req_len)
            2'd1: begin
                rd_data = {24'd0, rd_word[{lane, 3'b000} +: 8]};
                wr_word = rd_word;
                wr_word[{lane, 3'b000} +: 8] = req_data[7:0];
            end
            2'd2: begin
                rd_data = {16'd0, rd_word[{lane[1], 4'b0000} +: 16]};
                wr_word = rd_word;
                wr_word[{lane[1], 4'b0000} +: 16] = req_data[15:0];
            end
            default: begin
                rd_data = rd_word;
                wr_word = req_data;
            end
        endcase
        resp_next = {req_type, req_len, (req_type ? 32'd0 : rd_data)};
    end

    // Array write at the accept edge; a read in the following cycle sees it.
    always_ff @(posedge clk) begin
        if (accept && req_type) begin
            mem[word_idx] <= wr_word;
        end
    end

    // Fixed-latency response shift; it never stalls and reset drops in-flight entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_val <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_msg[i] <= '0;
            end
        end else begin
            pipe_val[0] <= accept;
            pipe_msg[0] <= accept ? resp_next : 35'd0;
            for (int i = 1; i < LAT; i++) begin
                pipe_val[i] <= pipe_val[i-1];
                pipe_msg[i] <= pipe_msg[i-1];
            end
        end
    end

    assign memresp_val = pipe_val[LAT-1];
    assign memresp_msg = pipe_msg[LAT-1];

    generate
        if (STALL_PERIOD > 0) begin : g_stall
            localparam int CNT_W = $clog2(STALL_PERIOD + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_PERIOD - 1);
            logic [CNT_W-1:0] cnt;

            // Every STALL_PERIOD-th accept drops memreq_rdy for the following cycle.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt     <= '0;
                    stall_q <= 1'b0;
                end else begin
                    stall_q <= 1'b0;
                    if (accept) begin
                        if (cnt == CNT_LAST) begin
                            cnt     <= '0;
                            stall_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
            end
        end else begin : g_no_stall
            assign stall_q = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Bench for riscv_mem_responder. Four instances with different parameters are
// driven one at a time. A byte-addressed reference memory and per-instance
// queues of expected responses (due cycle plus message) predict every response.
module tb_riscv_mem_responder;

    localparam int ABITS_T [4] = '{10, 10, 10, 4};
    localparam int LAT_T   [4] = '{1, 3, 4, 1};
    localparam int PER_T   [4] = '{0, 0, 2, 0};

    typedef struct {
        int          due;
        logic [34:0] msg;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0][66:0]  req_msg;
    logic [3:0]        req_val;
    logic [3:0]        req_rdy;
    logic [3:0][34:0]  resp_msg;
    logic [3:0]        resp_val;

    int                n_tests = 0;
    int                n_fail  = 0;
    int                cyc     = 0;
    exp_t              exp_q [4][$];
    logic [7:0]        ref_mem [int];
    int                acc_cnt [4];
    int                stall_cyc [4];
    bit                rdy_log [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_mem_responder #(.ADDR_BITS(10), .LAT(1), .STALL_PERIOD(0)) u_lat1 (
        .clk(clk), .reset(reset),
        .memreq_msg(req_msg[0]), .memreq_val(req_val[0]), .memreq_rdy(req_rdy[0]),
        .memresp_msg(resp_msg[0]), .memresp_val(resp_val[0]));

    riscv_mem_responder #(.ADDR_BITS(10), .LAT(3), .STALL_PERIOD(0)) u_lat3 (
        .clk(clk), .reset(reset),
        .memreq_msg(req_msg[1]), .memreq_val(req_val[1]), .memreq_rdy(req_rdy[1]),
        .memresp_msg(resp_msg[1]), .memresp_val(resp_val[1]));

    riscv_mem_responder #(.ADDR_BITS(10), .LAT(4), .STALL_PERIOD(2)) u_stall (
        .clk(clk), .reset(reset),
        .memreq_msg(req_msg[2]), .memreq_val(req_val[2]), .memreq_rdy(req_rdy[2]),
        .memresp_msg(resp_msg[2]), .memresp_val(resp_val[2]));

    riscv_mem_responder #(.ADDR_BITS(4), .LAT(1), .STALL_PERIOD(0)) u_small (
        .clk(clk), .reset(reset),
        .memreq_msg(req_msg[3]), .memreq_val(req_val[3]), .memreq_rdy(req_rdy[3]),
        .memresp_msg(resp_msg[3]), .memresp_val(resp_val[3]));

    task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            acc_cnt[k]   = 0;
            stall_cyc[k] = -1;
        end
    endtask

    // Reference behaviour of one accepted request, seen as operations on bytes.
    task automatic model_accept(input int k, input int c, input bit wr,
                                input logic [31:0] addr, input logic [1:0] len,
                                input logic [31:0] data);
        int          sz   = 4 << ABITS_T[k];
        int          off  = int'(addr & 32'(sz - 1));
        int          b    = k * 8192 + off;
        int          base = k * 8192 + (off & ~3);
        int          h    = base + (((off & 2) != 0) ? 2 : 0);
        logic [31:0] rd   = 32'd0;
        exp_t        e;
        if (wr) begin
            if (len == 2'd1) begin
                ref_mem[b] = data[7:0];
            end else if (len == 2'd2) begin
                ref_mem[h]   = data[7:0];
                ref_mem[h+1] = data[15:8];
            end else begin
                for (int i = 0; i < 4; i++) ref_mem[base+i] = data[8*i +: 8];
            end
        end else begin
            if (len == 2'd1)      rd = {24'd0, ref_mem[b]};
            else if (len == 2'd2) rd = {16'd0, ref_mem[h+1], ref_mem[h]};
            else rd = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
        end
        e.due = c + LAT_T[k];
        e.msg = {wr, len, rd};
        exp_q[k].push_back(e);
        acc_cnt[k]++;
        if (PER_T[k] > 0 && (acc_cnt[k] % PER_T[k]) == 0) stall_cyc[k] = c + 1;
    endtask

    // Present one request on instance k and hold it until accepted.
    task automatic send(input int k, input bit wr, input logic [31:0] addr,
                        input logic [1:0] len, input logic [31:0] data);
        bit done = 1'b0;
        bit exp_rdy;
        @(negedge clk);
        req_val = '0;
        req_msg[k] = {wr, addr, len, data};
        req_val[k] = 1'b1;
        for (int t = 0; t < 4 && !done; t++) begin
            exp_rdy = (cyc != stall_cyc[k]);
            rdy_log.push_back(req_rdy[k]);
            check($sformatf("rdy[%0d]", k), {66'd0, req_rdy[k]}, {66'd0, exp_rdy});
            if (exp_rdy) begin
                model_accept(k, cyc, wr, addr, len, data);
                done = 1'b1;
            end
            @(posedge clk);
            if (!done) @(negedge clk);
        end
        if (!done) check($sformatf("accept_timeout[%0d]", k), {66'd0, req_rdy[k]}, 67'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_val = '0;
        end
    endtask

    // Response monitor, sampling away from the rising edge.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (reset) begin
                check($sformatf("rst_resp_val[%0d]", k), {66'd0, resp_val[k]}, 67'd0);
                check($sformatf("rst_resp_msg[%0d]", k), {32'd0, resp_msg[k]}, 67'd0);
                check($sformatf("rst_req_rdy[%0d]", k), {66'd0, req_rdy[k]}, 67'd0);
            end else if (resp_val[k]) begin
                if (exp_q[k].size() == 0) begin
                    check($sformatf("unexpected_resp[%0d]", k), {66'd0, resp_val[k]}, 67'd0);
                end else begin
                    e = exp_q[k].pop_front();
                    check($sformatf("resp_cycle[%0d]", k), 67'(cyc), 67'(e.due));
                    check($sformatf("resp_msg[%0d]", k), {32'd0, resp_msg[k]}, {32'd0, e.msg});
                end
            end else if (exp_q[k].size() != 0 && exp_q[k][0].due <= cyc) begin
                check($sformatf("resp_missing[%0d]", k), {66'd0, resp_val[k]}, 67'd1);
                void'(exp_q[k].pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, tests %0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          exp_pat [8] = '{1, 1, 0, 1, 1, 0, 1, 1};
        logic [31:0] hi_mask;
        logic [31:0] addr;

        reset   = 1'b1;
        req_val = '0;
        req_msg = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Stall pattern with requests presented back to back.
        rdy_log.delete();
        send(2, 1'b1, 32'h0, 2'd0, 32'h0101_0101);
        send(2, 1'b1, 32'h4, 2'd0, 32'h0202_0202);
        send(2, 1'b1, 32'h8, 2'd0, 32'h0303_0303);
        send(2, 1'b0, 32'h0, 2'd0, 32'h0);
        send(2, 1'b0, 32'h4, 2'd0, 32'h0);
        send(2, 1'b0, 32'h8, 2'd0, 32'h0);
        check("stall_log_len", 67'(rdy_log.size()), 67'd8);
        for (int i = 0; i < 8 && i < rdy_log.size(); i++) begin
            check($sformatf("stall_rdy_%0d", i), {66'd0, rdy_log[i]}, {66'd0, exp_pat[i]});
        end
        idle(6);

        // Word write then read, then byte/halfword accesses on the same word.
        send(0, 1'b1, 32'h100, 2'd0, 32'hDEAD_BEEF);
        send(0, 1'b0, 32'h100, 2'd0, 32'h0);
        send(0, 1'b1, 32'h103, 2'd1, 32'h0000_005A);
        send(0, 1'b0, 32'h102, 2'd2, 32'h0);
        send(0, 1'b0, 32'h101, 2'd1, 32'h0);
        send(0, 1'b0, 32'h100, 2'd3, 32'h0);
        idle(3);

        // Back-to-back reads on the LAT=3 instance.
        send(1, 1'b1, 32'h0, 2'd0, 32'hA0A0_0000);
        send(1, 1'b1, 32'h4, 2'd0, 32'hA0A0_0004);
        send(1, 1'b1, 32'h8, 2'd0, 32'hA0A0_0008);
        idle(4);
        send(1, 1'b0, 32'h0, 2'd0, 32'h0);
        send(1, 1'b0, 32'h4, 2'd0, 32'h0);
        send(1, 1'b0, 32'h8, 2'd0, 32'h0);
        idle(6);

        // Address wrap on the 16-word instance.
        send(3, 1'b1, 32'h40, 2'd0, 32'h1111_1111);
        send(3, 1'b0, 32'h00, 2'd0, 32'h0);
        idle(3);

        // Reset one cycle after an accept: response is dropped, memory persists.
        send(1, 1'b1, 32'h200, 2'd0, 32'hCAFE_F00D);
        idle(4);
        send(1, 1'b0, 32'h200, 2'd0, 32'h0);
        @(negedge clk);
        reset   = 1'b1;
        req_val = '0;
        model_reset();
        #1;
        check("mid_reset_rdy", {66'd0, req_rdy[1]}, 67'd0);
        check("mid_reset_val", {66'd0, resp_val[1]}, 67'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(6);
        send(1, 1'b0, 32'h200, 2'd0, 32'h0);
        send(1, 1'b0, 32'h202, 2'd2, 32'h0);
        idle(6);

        // Randomized traffic: prefill a 16-word window, then mixed accesses.
        for (int k = 0; k < 4; k++) begin
            hi_mask = ~((32'd4 << ABITS_T[k]) - 32'd1);
            for (int w = 0; w < 16; w++) begin
                send(k, 1'b1, 32'(4 * w), 2'd0, $urandom());
            end
            for (int i = 0; i < 40; i++) begin
                addr = ($urandom() & hi_mask) | 32'($urandom_range(0, 63));
                send(k, 1'($urandom_range(0, 1)), addr, 2'($urandom_range(0, 3)), $urandom());
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            idle(6);
        end

        idle(8);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drained[%0d]", k), 67'(exp_q[k].size()), 67'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
